// File: rtl/approx_dot_accum.sv
// Accumulates LEN unsigned 16-bit products into a saturating ACC_W-bit dot product.
// The result is presented on a valid/ready port. The product is registered before the adder.
module approx_dot_accum #(
    parameter int LEN   = 8,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);
    localparam int               CNT_W    = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      prod_r_q, prod_r_d;
    logic             pv_q, pv_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             take;
    logic [ACC_W:0]   sum_ext;

    assign in_ready  = (state_q == ST_ACC) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign take      = out_valid && out_ready;
    assign out_sum   = out_valid ? acc_q : '0;
    assign out_ovf   = out_valid && ovf_q;

    // One extra bit exposes the carry that triggers saturation.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, prod_r_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_r_d = prod_r_q;
        pv_d     = 1'b0;
        acc_d    = acc_q;
        ovf_d    = ovf_q;

        if (pv_q) begin
            if (sum_ext[ACC_W]) begin
                acc_d = ACC_MAX;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum_ext[ACC_W-1:0];
            end
        end

        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    prod_r_d = prod;
                    pv_d     = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (take) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase

        // Abort wins over accept, drain and handshake alike.
        if (flush) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            pv_d    = 1'b0;
            state_d = ST_ACC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_ACC;
            cnt_q    <= '0;
            prod_r_q <= '0;
            pv_q     <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_r_q <= prod_r_d;
            pv_q     <= pv_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_approx_dot_accum.sv
// Bench for approx_dot_accum: one LEN=8/ACC_W=24 unit and one LEN=4/ACC_W=17 unit.
// Expected sums come from a clamped integer sum of the accepted products.
module tb_approx_dot_accum;
    localparam int LEN0 = 8;
    localparam int W0   = 24;
    localparam int LEN1 = 4;
    localparam int W1   = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  flush;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [1:0]  out_ovf;
    logic [15:0] prod [2];
    logic [W0-1:0] sum0;
    logic [W1-1:0] sum1;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint m_sum [2];

    always #5 clk = ~clk;

    approx_dot_accum #(.LEN(LEN0), .ACC_W(W0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .prod(prod[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum0), .out_ovf(out_ovf[0])
    );

    approx_dot_accum #(.LEN(LEN1), .ACC_W(W1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .prod(prod[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum1), .out_ovf(out_ovf[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sum_of(input int u);
        return (u == 0) ? 64'(sum0) : 64'(sum1);
    endfunction

    function automatic longint max_of(input int u);
        return (u == 0) ? ((longint'(1) << W0) - 1) : ((longint'(1) << W1) - 1);
    endfunction

    function automatic int len_of(input int u);
        return (u == 0) ? LEN0 : LEN1;
    endfunction

    // Saturation in a sum of non-negative terms equals clamping the exact total.
    function automatic logic [63:0] exp_sum(input int u);
        return (m_sum[u] > max_of(u)) ? 64'(max_of(u)) : 64'(m_sum[u]);
    endfunction

    function automatic logic [63:0] exp_ovf(input int u);
        return (m_sum[u] > max_of(u)) ? 64'd1 : 64'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int u, input logic [15:0] val, input int max_gap);
        int gaps;
        gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        for (int g = 0; g < gaps; g++) begin
            in_valid[u] = 1'b0;
            prod[u]     = 16'($urandom);
            check("gap_in_ready", 64'(in_ready[u]), 64'd1);
            tick();
        end
        in_valid[u] = 1'b1;
        prod[u]     = val;
        check("in_ready", 64'(in_ready[u]), 64'd1);
        tick();
        in_valid[u] = 1'b0;
        m_sum[u] += longint'(val);
    endtask

    // Called in the DRAIN cycle right after the last accept.
    task automatic expect_result(input int u, input int hold, input logic junk);
        check("drain_out_valid", 64'(out_valid[u]), 64'd0);
        check("drain_in_ready", 64'(in_ready[u]), 64'd0);
        in_valid[u] = junk;
        prod[u]     = 16'd7;
        tick();
        for (int h = 0; h <= hold; h++) begin
            check("done_out_valid", 64'(out_valid[u]), 64'd1);
            check("done_sum", sum_of(u), exp_sum(u));
            check("done_ovf", 64'(out_ovf[u]), exp_ovf(u));
            check("done_in_ready", 64'(in_ready[u]), 64'd0);
            if (h == hold) out_ready[u] = 1'b1;
            tick();
        end
        out_ready[u] = 1'b0;
        in_valid[u]  = 1'b0;
        check("post_in_ready", 64'(in_ready[u]), 64'd1);
        check("post_out_valid", 64'(out_valid[u]), 64'd0);
        check("post_sum", sum_of(u), 64'd0);
        m_sum[u] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        flush     = '0;
        in_valid  = '0;
        out_ready = '0;
        prod[0]   = '0;
        prod[1]   = '0;
        m_sum[0]  = 0;
        m_sum[1]  = 0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("rst_in_ready", 64'(in_ready[u]), 64'd0);
            check("rst_out_valid", 64'(out_valid[u]), 64'd0);
            check("rst_sum", sum_of(u), 64'd0);
            check("rst_ovf", 64'(out_ovf[u]), 64'd0);
        end
        rst = 1'b0;
        #1;
        check("rel_in_ready0", 64'(in_ready[0]), 64'd1);
        check("rel_in_ready1", 64'(in_ready[1]), 64'd1);
        tick();

        // 1..8 back to back, result taken on its first valid cycle
        for (int i = 1; i <= 8; i++) feed(0, 16'(i), 0);
        check("seq_model_sum", exp_sum(0), 64'd36);
        expect_result(0, 0, 1'b0);

        // 65025 x8 with random input gaps
        for (int i = 0; i < 8; i++) feed(0, 16'd65025, 3);
        check("big_model_sum", exp_sum(0), 64'd520200);
        expect_result(0, 0, 1'b0);

        // Saturation on the 17-bit unit, then a clean frame
        for (int i = 0; i < 4; i++) feed(1, 16'hFFFF, 0);
        expect_result(1, 0, 1'b0);
        for (int i = 1; i <= 4; i++) feed(1, 16'(i), 0);
        expect_result(1, 0, 1'b0);

        // Back-pressure for 5 cycles with junk 7s offered
        for (int i = 0; i < 8; i++) feed(0, 16'd11, 1);
        expect_result(0, 5, 1'b1);
        for (int i = 0; i < 8; i++) feed(0, 16'd1, 0);
        expect_result(0, 0, 1'b0);

        // Flush after 3 accepts, coinciding with an offered beat
        feed(0, 16'd100, 0);
        feed(0, 16'd200, 0);
        feed(0, 16'd300, 0);
        flush[0]    = 1'b1;
        in_valid[0] = 1'b1;
        prod[0]     = 16'd999;
        tick();
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        m_sum[0]    = 0;
        check("flush_in_ready", 64'(in_ready[0]), 64'd1);
        check("flush_out_valid", 64'(out_valid[0]), 64'd0);
        for (int i = 0; i < 8; i++) feed(0, 16'd1, 0);
        check("flush_model_sum", exp_sum(0), 64'd8);
        expect_result(0, 0, 1'b0);

        // Flush in DONE drops the pending result
        for (int i = 0; i < 4; i++) feed(1, 16'd9, 0);
        tick();
        check("fdone_out_valid", 64'(out_valid[1]), 64'd1);
        flush[1] = 1'b1;
        tick();
        flush[1] = 1'b0;
        m_sum[1] = 0;
        check("fdone_dropped", 64'(out_valid[1]), 64'd0);
        check("fdone_sum", sum_of(1), 64'd0);
        check("fdone_in_ready", 64'(in_ready[1]), 64'd1);
        for (int i = 0; i < 4; i++) feed(1, 16'd3, 0);
        expect_result(1, 0, 1'b0);

        // Reset mid-frame
        for (int i = 0; i < 3; i++) feed(0, 16'd5, 0);
        rst = 1'b1;
        #1;
        check("mrst_in_ready", 64'(in_ready[0]), 64'd0);
        check("mrst_out_valid", 64'(out_valid[0]), 64'd0);
        check("mrst_sum", sum_of(0), 64'd0);
        tick();
        rst = 1'b0;
        m_sum[0] = 0;
        #1;
        check("mrst_rel_in_ready", 64'(in_ready[0]), 64'd1);

        // Reset while a result is pending
        for (int i = 0; i < 8; i++) feed(0, 16'd3, 0);
        tick();
        check("drst_pre_valid", 64'(out_valid[0]), 64'd1);
        rst = 1'b1;
        #1;
        check("drst_out_valid", 64'(out_valid[0]), 64'd0);
        check("drst_sum", sum_of(0), 64'd0);
        check("drst_in_ready", 64'(in_ready[0]), 64'd0);
        tick();
        rst = 1'b0;
        m_sum[0] = 0;
        #1;
        for (int i = 0; i < 8; i++) feed(0, 16'd2, 0);
        check("rst2_model_sum", exp_sum(0), 64'd16);
        expect_result(0, 0, 1'b0);

        // Randomized frames on both units
        for (int f = 0; f < 6; f++) begin
            for (int u = 0; u < 2; u++) begin
                for (int i = 0; i < len_of(u); i++) feed(u, 16'($urandom), 2);
                expect_result(u, int'($urandom_range(2, 0)), 1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/approx_dot_accum.md
# approx_dot_accum

Sequential accumulation stage directly downstream of the 8x8 approximate multipliers. It consumes one 16-bit product per accepted beat and sums LEN consecutive products into a dot-product result. It presents the result on a valid/ready output port. It registers the combinational multiplier output before the adder, so the multiplier-to-adder path is broken at the block boundary.

## Interface
- LEN, default 8: number of products per dot product; legal range 1..255.
- ACC_W, default 24: accumulator and result width; legal range 16..32.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort of the current frame
- in_valid  in  1  prod is valid this cycle
- in_ready  out  1  block accepts prod this cycle
- prod  in  16  unsigned product from the approximate multiplier (its R output)
- out_valid  out  1  out_sum/out_ovf hold a completed result
- out_ready  in  1  consumer takes the result this cycle
- out_sum  out  ACC_W  saturated unsigned sum of LEN products
- out_ovf  out  1  saturation occurred during this frame

## Operation
- One clock, clk. Reset is asynchronous and active-high, on rst.
- Internal state:
  - State register: ACC, DRAIN, DONE.
  - Beat counter cnt, width clog2(LEN+1).
  - prod_r (16 bits) and pv (1 bit), the pipeline register.
  - acc (ACC_W bits) and ovf (1 bit).
- Reset (async) clears every register and sets state = ACC. in_ready is forced to 0 while rst is high.
- Output reset values: in_ready 0 while rst is high, 1 after release; out_valid 0; out_sum 0; out_ovf 0.
- in_ready = (state == ACC) and not rst. An accept is in_valid && in_ready.
- On accept:
  - prod_r <= prod, pv <= 1, cnt <= cnt+1.
  - If cnt == LEN-1, state <= DRAIN.
- With no accept, pv <= 0.
- If pv == 1, form s = acc + prod_r at ACC_W+1 bits:
  - Carry out: acc <= 2^ACC_W-1 and ovf <= 1.
  - Otherwise acc <= s[ACC_W-1:0].
  - Once saturated, acc stays at the maximum for the rest of the frame.
- DRAIN lasts one cycle: pv holds the final product, the adder absorbs it, then state <= DONE.
- In DONE:
  - out_valid = 1, out_sum = acc, out_ovf = ovf.
  - Outputs stay stable while out_ready is low.
- On out_valid && out_ready: acc, ovf, cnt <= 0 and state <= ACC.
- When out_valid = 0, out_sum and out_ovf read 0.
- flush has priority over every other event in every state. It clears acc, ovf, cnt, pv and sets state = ACC. Any product on prod in the flush cycle is discarded, and a pending result in DONE is dropped.
- in_ready is 0 in DRAIN and DONE. Any in_valid in those states is ignored and is not counted.

## Timing
- A product is added to acc one cycle after acceptance.
- Last accept in cycle t: DRAIN in t+1, out_valid = 1 from t+2.
- An out_ready handshake in cycle u makes in_ready = 1 in u+1.
- Minimum frame period is LEN+2 cycles at full throughput with out_ready tied high.
- in_valid gaps inside a frame stall cnt only. Partial sums are preserved.
- LEN = 1: accept, then DRAIN, then DONE, the same 2-cycle latency.
- rst asserted mid-frame or in DONE: all outputs return immediately to their reset values and the frame is lost.
- Simultaneous accept and flush: flush wins and cnt ends at 0.

## Test plan
- LEN=8, ACC_W=24: stream products 1..8 back-to-back with out_ready=1 -> out_valid in the cycle 2 after the 8th accept; out_sum=36, out_ovf=0; in_ready=1 the following cycle.
- LEN=8: drive prod=65025 for 8 beats with random in_valid gaps -> out_sum=520200, out_ovf=0; cnt advances only on accepts.
- LEN=4, ACC_W=17: drive prod=65535 x4 -> out_sum=131071, out_ovf=1; the next frame of 1,2,3,4 -> out_sum=10, out_ovf=0.
- Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with prod=7 -> out_sum unchanged; in_ready=0; the 7s are not counted in the next frame.
- Pulse flush after 3 of 8 accepts (values 100, 200, 300), then stream eight 1s -> out_sum=8.
- Assert rst for 1 cycle mid-frame and also while out_valid=1 -> out_valid=0, out_sum=0, in_ready=0 during rst; the next full frame of 2s -> out_sum=16.
